parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
Serial frame transmitter that sits directly downstream of the 9-bit parity generator (data x0..x8, outputs ep/op). It accepts one data word together with the generator's ep/op results through a valid/ready handshake. It serialises start bit, data LSB-first, the selected parity bit and a stop bit onto a single line at a programmable bit period. It also cross-checks the supplied parity against its own reduction and flags any mismatch.

Parameters:
DATA_W, 9, data word width; matches the generator's x0..x8.
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range >= 1.
PARITY_ODD, 0, 0 = transmit ep; 1 = transmit op.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
din  input  DATA_W  data word; bit 0 = x0.
ep  input  1  even-parity bit from generator.
op  input  1  odd-parity bit from generator.
din_valid  input  1  din/ep/op valid.
din_ready  output  1  block can accept a word.
tx  output  1  serial line; idle high.
tx_busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse at end of stop bit.
par_err  output  1  one-cycle pulse on accept if parity inputs are inconsistent.

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx=1, din_ready=1, tx_busy=0, frame_done=0, par_err=0, counters=0, shift register=0.
- Reset asserted mid-frame: tx forced to 1 immediately, not on the next edge. The frame is abandoned and no frame_done is issued.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE: din_ready=1, tx=1, tx_busy=0.
  - Accept when din_valid && din_ready on a clk edge.
  - On accept, capture din into the shift register. Capture par_bit = PARITY_ODD ? op : ep.
  - On accept, reset the bit-period counter and bit counter, then go to START.
- Accept-time parity check:
  - par_err pulses high for exactly the cycle after accept when ep != ^din or op != ~ep.
  - The frame is still sent using the captured par_bit. The captured value is never corrected.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx = shift register bit 0 for CLKS_PER_BIT cycles. Then shift right and increment the bit counter. After DATA_W bits, go to PARITY.
- PARITY: tx = par_bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - frame_done pulses in the last cycle of STOP.
  - Next state is IDLE.
- Outside IDLE: din_ready=0 and tx_busy=1. din/ep/op changes during a frame have no effect.
- Latency: tx falls on the first cycle after the accept edge.
- Frame length: exactly (DATA_W+3)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle inclusive.
- Back-to-back: at least one IDLE cycle with din_ready=1 between frames. If din_valid is held high, the next word is accepted on that IDLE cycle.
- Bit-period counter: width clog2(CLKS_PER_BIT)+1. It wraps to 0 at CLKS_PER_BIT-1.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; no zero-length states.
- Bit counter: width clog2(DATA_W)+1. It stops at DATA_W and never wraps into a tenth data bit.
- tx is registered and glitch-free.

Test Plan:
1. Nominal even parity. Setup: PARITY_ODD=0, CLKS_PER_BIT=4. Stimulus: din=9'b000000111, ep=1, op=0, valid for 1 cycle. Required response:
   - tx sequence 0,1,1,1,0,0,0,0,0,0,1,1, each bit held 4 cycles.
   - frame_done at cycle 48 after accept.
   - par_err=0.
2. Odd parity select. Setup: PARITY_ODD=1. Stimulus: din=9'b110000000, ep=0, op=1. Required response:
   - tx sequence 0,0,0,0,0,0,0,0,1,1,1,1.
   - par_err=0.
3. Inconsistent inputs. Stimulus: din=9'b000000001, ep=0, op=0. Required response:
   - par_err pulses once.
   - Transmitted parity bit (PARITY_ODD=0) = 0, as captured.
4. Back-to-back with din_valid held high. Stimulus: din=9'b111110001, then 9'b010000010. Required response:
   - Exactly one IDLE cycle between frames.
   - Second frame data LSB-first = 0,1,0,0,0,0,0,1,0.
   - Parity bit = 0.
5. Reset mid-frame. Stimulus: assert rst_n=0 during the DATA state on a data bit of value 0. Required response:
   - tx=1 within the same cycle (asynchronous).
   - din_ready=1 after release.
   - No frame_done.
   - The next accepted word is transmitted correctly.
6. Minimum period. Setup: CLKS_PER_BIT=1. Stimulus: din=9'b100000001, ep=0, op=1. Required response:
   - 12-cycle frame 0,1,0,0,0,0,0,0,0,1,0,1.
   - frame_done on cycle 12.

Source files
------------

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, parity, stop.
// Also cross-checks the supplied ep/op against its own parity reduction on accept.
module parity_frame_tx #(
    parameter int DATA_W       = 9,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              ep,
    input  logic              op,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              frame_done,
    output logic              par_err
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bit_q, par_bit_d;
    logic              tx_q, tx_d;
    logic              par_err_q, par_err_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    shift_d   = din;
                    par_bit_d = (PARITY_ODD != 0) ? op : ep;
                    par_err_d = (ep != ^din) || (op != ~ep);
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next-state view so the line moves on the same edge as the FSM
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            par_err_q <= par_err_d;
        end
    end

    assign din_ready  = (state_q == S_IDLE);
    assign tx_busy    = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && bit_end;
    assign tx         = tx_q;
    assign par_err    = par_err_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: three instances (even/4, odd/4, even/1)
// driven from a vector table plus back-to-back and mid-frame reset sequences.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] din;
    logic       ep, op;
    logic [2:0] valid_v;
    logic [2:0] rdy_v, tx_v, busy_v, done_v, perr_v;
    logic [1:0] cur_sel;
    logic       rdy_m, tx_m, busy_m, done_m, perr_m;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(9), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst_n(rst_n), .din(din), .ep(ep), .op(op), .din_valid(valid_v[0]),
        .din_ready(rdy_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]),
        .frame_done(done_v[0]), .par_err(perr_v[0]));

    parity_frame_tx #(.DATA_W(9), .CLKS_PER_BIT(4), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .din(din), .ep(ep), .op(op), .din_valid(valid_v[1]),
        .din_ready(rdy_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]),
        .frame_done(done_v[1]), .par_err(perr_v[1]));

    parity_frame_tx #(.DATA_W(9), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .din(din), .ep(ep), .op(op), .din_valid(valid_v[2]),
        .din_ready(rdy_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]),
        .frame_done(done_v[2]), .par_err(perr_v[2]));

    always_comb begin
        rdy_m  = rdy_v[cur_sel];
        tx_m   = tx_v[cur_sel];
        busy_m = busy_v[cur_sel];
        done_m = done_v[cur_sel];
        perr_m = perr_v[cur_sel];
    end

    typedef struct {
        logic [1:0]  sel;
        logic [8:0]  din;
        logic        ep;
        logic        op;
        logic [11:0] frame;   // transmission order, leftmost bit first
        int          perr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int cpb_of(input logic [1:0] sel);
        return (sel == 2'd2) ? 1 : 4;
    endfunction

    // Presents a word at a negedge; returns just after the accepting posedge.
    task automatic start_frame(input logic [1:0] sel, input logic [8:0] d,
                               input logic e, input logic o, input string tag);
        @(negedge clk);
        cur_sel = sel;
        din = d; ep = e; op = o;
        valid_v[sel] = 1'b1;
        #1;
        check({tag, " ready_before_accept"}, int'(rdy_m), 1);
        @(posedge clk);
    endtask

    task automatic run_frame(input logic [1:0] sel, input logic [11:0] exp_f,
                             input logic drop, input string tag);
        int cpb, k, done_cnt, done_cyc, perr_cnt, rdy1;
        logic [11:0] bad;
        cpb = cpb_of(sel);
        bad = '0; done_cnt = 0; done_cyc = -1; perr_cnt = 0; rdy1 = -1;
        for (int c = 1; c <= 12 * cpb; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (drop) valid_v[sel] = 1'b0;
                rdy1 = int'(rdy_m);
            end
            k = (c - 1) / cpb;
            if (tx_m !== exp_f[11-k]) bad[k] = 1'b1;
            if (done_m) begin done_cnt++; done_cyc = c; end
            if (perr_m) perr_cnt++;
        end
        for (int b = 0; b < 12; b++)
            check($sformatf("%s frame_bit%0d", tag, b), int'(bad[b] ? ~exp_f[11-b] : exp_f[11-b]),
                  int'(exp_f[11-b]));
        check({tag, " ready_in_frame"}, rdy1, 0);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_cycle"}, done_cyc, 12 * cpb);
        last_perr = perr_cnt;
    endtask

    int last_perr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, bad_tx;
        vecs[0] = '{2'd0, 9'b000000111, 1'b1, 1'b0, 12'b011100000011, 0};
        vecs[1] = '{2'd1, 9'b110000000, 1'b0, 1'b1, 12'b000000001111, 0};
        vecs[2] = '{2'd0, 9'b000000001, 1'b0, 1'b0, 12'b010000000001, 1};
        vecs[3] = '{2'd2, 9'b100000001, 1'b0, 1'b1, 12'b010000000101, 0};
        vecs[4] = '{2'd1, 9'b000000001, 1'b1, 1'b1, 12'b010000000011, 1};
        vecs[5] = '{2'd0, 9'b101010101, 1'b1, 1'b0, 12'b010101010111, 0};

        rst_n = 1'b0; valid_v = '0; din = '0; ep = 1'b0; op = 1'b0; cur_sel = 2'd0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset tx[%0d]", s), int'(tx_v[s]), 1);
            check($sformatf("reset ready[%0d]", s), int'(rdy_v[s]), 1);
            check($sformatf("reset busy[%0d]", s), int'(busy_v[s]), 0);
            check($sformatf("reset done[%0d]", s), int'(done_v[s]), 0);
            check($sformatf("reset perr[%0d]", s), int'(perr_v[s]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_frame(vecs[i].sel, vecs[i].din, vecs[i].ep, vecs[i].op, tag);
            run_frame(vecs[i].sel, vecs[i].frame, 1'b1, tag);
            check({tag, " par_err_pulses"}, last_perr, vecs[i].perr);
            @(negedge clk);
            check({tag, " idle_ready"}, int'(rdy_m), 1);
            check({tag, " idle_tx"}, int'(tx_m), 1);
        end

        // Back-to-back with din_valid held; din changes mid-frame must not disturb frame 1
        start_frame(2'd0, 9'b111110001, 1'b0, 1'b1, "b2b1");
        #1;
        din = 9'b010000010; ep = 1'b0; op = 1'b1;
        run_frame(2'd0, 12'b010001111101, 1'b0, "b2b1");
        check("b2b1 par_err_pulses", last_perr, 0);
        @(negedge clk);
        check("b2b gap ready", int'(rdy_m), 1);
        check("b2b gap busy", int'(busy_m), 0);
        check("b2b gap tx", int'(tx_m), 1);
        @(posedge clk);
        run_frame(2'd0, 12'b001000001001, 1'b1, "b2b2");
        check("b2b2 par_err_pulses", last_perr, 0);
        @(negedge clk);

        // Reset during a zero data bit (data bit 1 occupies cycles 9..12)
        start_frame(2'd0, 9'b000000001, 1'b1, 1'b0, "rst");
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) valid_v[0] = 1'b0;
        end
        check("rst pre tx", int'(tx_m), 0);
        check("rst pre busy", int'(busy_m), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst async tx", int'(tx_m), 1);
        check("rst async ready", int'(rdy_m), 1);
        check("rst async busy", int'(busy_m), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0; bad_tx = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_m) dc++;
            if (tx_m !== 1'b1) bad_tx++;
        end
        check("rst no frame_done", dc, 0);
        check("rst idle tx cycles low", bad_tx, 0);
        check("rst ready after release", int'(rdy_m), 1);
        start_frame(2'd0, vecs[0].din, vecs[0].ep, vecs[0].op, "post_rst");
        run_frame(2'd0, vecs[0].frame, 1'b1, "post_rst");
        check("post_rst par_err_pulses", last_perr, 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
